// File: rtl/lcd_mmio_controller.sv
// ----------------------------------------------------------------------------
// lcd_mmio_controller
//   Memory-mapped HD44780-style LCD port. CPU stores to the DATA/CMD registers
//   are queued in a small FIFO; a timing FSM replays each entry onto the LCD
//   pins with programmable setup / pulse / hold / settle cycles.
//
//   Register map (addr[3:2]):
//     0 DATA   W  push {rs=1, wdata[7:0]}            reads 0
//     1 CMD    W  push {rs=0, wdata[7:0]}            reads 0
//     2 STATUS R  [0] busy [1] full [2] empty [8] overflow [23:16] fill count
//     3 CTRL   W  [0] clear overflow, [1] flush FIFO reads 0
//
// Ports
//   clk         system clock
//   rst_n       synchronous active-low reset
//   sel         chip select from the top-level address decode
//   addr        byte offset (addr[3:2] decoded)
//   wdata       store data
//   wenable     byte write enables (write when sel && wenable[0])
//   rdata       combinational read data selected by addr
//   lcd_data    LCD data bus
//   lcd_ctrl    {RS, RW}, RW always 0
//   lcd_enable  LCD enable strobe
//   busy        transfer in progress or FIFO not empty
// ----------------------------------------------------------------------------
module lcd_mmio_controller #(
    parameter int FIFO_DEPTH      = 8,
    parameter int SETUP_CYCLES    = 2,
    parameter int PULSE_CYCLES    = 4,
    parameter int HOLD_CYCLES     = 2,
    parameter int CMD_WAIT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wenable,
    output logic [31:0] rdata,
    output logic [7:0]  lcd_data,
    output logic [1:0]  lcd_ctrl,
    output logic        lcd_enable,
    output logic        busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = 16;

    localparam logic [CNT_W-1:0] FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [TMR_W-1:0] SETUP_LOAD    = TMR_W'(SETUP_CYCLES - 1);
    localparam logic [TMR_W-1:0] PULSE_LOAD    = TMR_W'(PULSE_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LOAD     = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] WAIT_LOAD     = TMR_W'(CMD_WAIT_CYCLES - 1);
    localparam bit               HAS_WAIT      = (CMD_WAIT_CYCLES != 32'sd0);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_WAIT  = 3'd4
    } state_t;

    // FIFO storage and bookkeeping
    logic [8:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             overflow_r;

    // Timing FSM and LCD pin registers
    state_t           state_r;
    state_t           state_nxt_s;
    logic [TMR_W-1:0] tmr_r;
    logic [TMR_W-1:0] tmr_nxt_s;
    logic             en_r;
    logic             en_nxt_s;
    logic [7:0]       data_r;
    logic [7:0]       data_nxt_s;
    logic [1:0]       ctrl_r;
    logic [1:0]       ctrl_nxt_s;

    // Bus decode and FIFO control
    logic             wr_s;
    logic             push_req_s;
    logic             push_rs_s;
    logic             ctrl_wr_s;
    logic             flush_s;
    logic             ovf_clr_s;
    logic             ovf_set_s;
    logic             push_ok_s;
    logic             pop_s;
    logic             full_s;
    logic             empty_s;
    logic             busy_s;
    logic [8:0]       head_s;
    logic [7:0]       fill_s;
    logic [31:0]      rdata_s;
    logic             unused_s;

    assign wr_s       = sel && wenable[0];
    assign push_req_s = wr_s && ((addr[3:2] == 2'd0) || (addr[3:2] == 2'd1));
    assign push_rs_s  = (addr[3:2] == 2'd0);
    assign ctrl_wr_s  = wr_s && (addr[3:2] == 2'd3);
    assign flush_s    = ctrl_wr_s && wdata[1];
    assign ovf_clr_s  = ctrl_wr_s && wdata[0];

    assign full_s     = (count_r == FIFO_FULL_CNT);
    assign empty_s    = (count_r == {CNT_W{1'b0}});
    // A flush discards a same-cycle push outright, so it never counts as overflow.
    assign push_ok_s  = push_req_s && !full_s && !flush_s;
    assign ovf_set_s  = push_req_s && full_s && !flush_s;
    assign head_s     = mem_r[rd_ptr_r];
    assign busy_s     = (state_r != ST_IDLE) || !empty_s;
    assign fill_s     = 8'(count_r);

    assign unused_s   = ^{wdata[31:8], wenable[3:1], addr[1:0]};

    // FIFO payload storage; contents are only meaningful below count_r.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= {push_rs_s, wdata[7:0]};
        end
    end

    // FIFO pointers and fill count; a pop already taken by the FSM survives a flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush_s) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky overflow flag; a set in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
        end else if (ovf_set_s) begin
            overflow_r <= 1'b1;
        end else if (ovf_clr_s) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // Next-state logic; one down-counter is reloaded on every state entry.
    always_comb begin
        state_nxt_s = state_r;
        tmr_nxt_s   = tmr_r;
        en_nxt_s    = en_r;
        data_nxt_s  = data_r;
        ctrl_nxt_s  = ctrl_r;
        pop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s       = 1'b1;
                    data_nxt_s  = head_s[7:0];
                    ctrl_nxt_s  = {head_s[8], 1'b0};
                    tmr_nxt_s   = SETUP_LOAD;
                    state_nxt_s = ST_SETUP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (tmr_r == {TMR_W{1'b0}}) begin
                    en_nxt_s    = 1'b1;
                    tmr_nxt_s   = PULSE_LOAD;
                    state_nxt_s = ST_PULSE;
                end else begin
                    tmr_nxt_s   = tmr_r - {{(TMR_W-1){1'b0}}, 1'b1};
                end
            end
            ST_PULSE: begin
                if (tmr_r == {TMR_W{1'b0}}) begin
                    en_nxt_s    = 1'b0;
                    tmr_nxt_s   = HOLD_LOAD;
                    state_nxt_s = ST_HOLD;
                end else begin
                    tmr_nxt_s   = tmr_r - {{(TMR_W-1){1'b0}}, 1'b1};
                end
            end
            ST_HOLD: begin
                if (tmr_r == {TMR_W{1'b0}}) begin
                    // Instructions (rs=0) need the extra controller settle time.
                    if (!ctrl_r[1] && HAS_WAIT) begin
                        tmr_nxt_s   = WAIT_LOAD;
                        state_nxt_s = ST_WAIT;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    tmr_nxt_s   = tmr_r - {{(TMR_W-1){1'b0}}, 1'b1};
                end
            end
            ST_WAIT: begin
                if (tmr_r == {TMR_W{1'b0}}) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    tmr_nxt_s   = tmr_r - {{(TMR_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                en_nxt_s    = 1'b0;
                tmr_nxt_s   = {TMR_W{1'b0}};
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, shared timer and registered LCD pins; reset aborts a transfer at once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            tmr_r   <= {TMR_W{1'b0}};
            en_r    <= 1'b0;
            data_r  <= 8'h00;
            ctrl_r  <= 2'b00;
        end else begin
            state_r <= state_nxt_s;
            tmr_r   <= tmr_nxt_s;
            en_r    <= en_nxt_s;
            data_r  <= data_nxt_s;
            ctrl_r  <= ctrl_nxt_s;
        end
    end

    // Read mux; independent of sel so the top level can register it as it likes.
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (addr[3:2])
            2'd2:    rdata_s = {8'h00, fill_s, 7'h00, overflow_r, 5'h00, empty_s, full_s, busy_s};
            default: rdata_s = 32'h0000_0000;
        endcase
    end

    assign rdata      = rdata_s;
    assign lcd_data   = data_r;
    assign lcd_ctrl   = ctrl_r;
    assign lcd_enable = en_r;
    assign busy       = busy_s;

`ifndef SYNTHESIS
    // Echo characters written to the display onto the simulation console.
    always @(negedge en_r) begin
        if (ctrl_r == 2'b10) begin
            $write("%c", data_r);
        end
    end
`endif

endmodule

// File: tb/tb_lcd_mmio_controller.sv
module tb_lcd_mmio_controller;

    localparam int SETUP = 2;
    localparam int PULSE = 4;
    localparam int HOLD  = 2;
    localparam int WAITC = 64;

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wenable;
    logic [31:0] rdata;
    logic [7:0]  lcd_data;
    logic [1:0]  lcd_ctrl;
    logic        lcd_enable;
    logic        busy;

    lcd_mmio_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel        (sel),
        .addr       (addr),
        .wdata      (wdata),
        .wenable    (wenable),
        .rdata      (rdata),
        .lcd_data   (lcd_data),
        .lcd_ctrl   (lcd_ctrl),
        .lcd_enable (lcd_enable),
        .busy       (busy)
    );

    typedef struct {
        bit          is_rd;
        bit          sel;
        logic [3:0]  wen;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        int         cyc;
        logic [1:0] ctrl;
        logic [7:0] data;
    } rise_t;

    int      n_checks = 0;
    int      n_errors = 0;
    int      cyc = 0;
    rise_t   rise_q[$];
    rise_t   exp_q[$];
    bit      chk_width = 1'b1;
    bit      en_prev = 1'b0;
    int      hi_cnt = 0;
    vec_t    vecs[12];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // LCD-side monitor: logs every enable rise and checks every pulse width.
    always @(negedge clk) begin
        if (lcd_enable === 1'b1) begin
            if (!en_prev) rise_q.push_back('{cyc, lcd_ctrl, lcd_data});
            hi_cnt++;
        end else begin
            if (en_prev && chk_width) check("pulse_width", 32'(hi_cnt), 32'(PULSE));
            hi_cnt = 0;
        end
        en_prev = (lcd_enable === 1'b1);
    end

    function automatic logic get_sig(input int which);
        return (which == 0) ? lcd_enable : busy;
    endfunction

    // Caller is at a negedge; returns the cycle index at which the signal reaches lvl.
    task automatic wait_level(input int which, input logic lvl, input int bound,
                              output int at, output bit ok);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < bound; i++) begin
            if (get_sig(which) === lvl) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; addr = a; wdata = d; wenable = 4'h1;
        @(posedge clk);
        #1;
        sel = 1'b0; wenable = 4'h0;
    endtask

    task automatic bus_read(input logic [3:0] a, input logic [31:0] exp, input string name);
        @(negedge clk);
        sel = 1'b1; addr = a; wenable = 4'h0;
        #1;
        check(name, rdata, exp);
    endtask

    // One write with full latency / width checks; FIFO must be empty and FSM idle.
    task automatic xfer_check(input bit rs, input logic [7:0] d);
        int w, t_rise, t_fall, t_idle;
        bit ok;
        bus_write(rs ? 4'h0 : 4'h4, {24'h0, d});
        w = cyc;
        @(negedge clk);
        @(negedge clk);
        check("x_data", {24'h0, lcd_data}, {24'h0, d});
        check("x_ctrl", {30'h0, lcd_ctrl}, {30'h0, rs, 1'b0});
        check("x_busy", {31'h0, busy}, 32'h1);
        wait_level(0, 1'b1, 20, t_rise, ok);
        check("x_rise_seen", {31'h0, ok}, 32'h1);
        check("x_setup", 32'(t_rise - w), 32'(1 + SETUP));
        wait_level(0, 1'b0, PULSE + 5, t_fall, ok);
        check("x_fall_seen", {31'h0, ok}, 32'h1);
        check("x_pulse", 32'(t_fall - t_rise), 32'(PULSE));
        wait_level(1, 1'b0, 200, t_idle, ok);
        check("x_idle_seen", {31'h0, ok}, 32'h1);
        check("x_hold", 32'(t_idle - t_fall), 32'(HOLD + (rs ? 0 : WAITC)));
        check("x_data_held", {24'h0, lcd_data}, {24'h0, d});
    endtask

    initial begin
        int t;
        bit ok;
        bit rs;
        logic [7:0] d;

        // addr 8 = STATUS, 0 = DATA, 4 = CMD, C = CTRL
        vecs[0]  = '{1'b1, 1'b1, 4'h0, 4'h8, 32'h0, 32'h0000_0004};
        vecs[1]  = '{1'b1, 1'b1, 4'h0, 4'h0, 32'h0, 32'h0000_0000};
        vecs[2]  = '{1'b1, 1'b1, 4'h0, 4'h4, 32'h0, 32'h0000_0000};
        vecs[3]  = '{1'b1, 1'b1, 4'h0, 4'hC, 32'h0, 32'h0000_0000};
        vecs[4]  = '{1'b0, 1'b1, 4'h1, 4'h4, 32'h0000_0001, 32'h0};
        vecs[5]  = '{1'b1, 1'b1, 4'h0, 4'h8, 32'h0, 32'h0001_0001};
        vecs[6]  = '{1'b1, 1'b1, 4'h0, 4'h8, 32'h0, 32'h0000_0005};
        vecs[7]  = '{1'b0, 1'b0, 4'hF, 4'h0, 32'h0000_0055, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 4'h0, 4'h8, 32'h0, 32'h0000_0005};
        vecs[9]  = '{1'b0, 1'b1, 4'hE, 4'h0, 32'h0000_0055, 32'h0};
        vecs[10] = '{1'b1, 1'b1, 4'h0, 4'h8, 32'h0, 32'h0000_0005};
        vecs[11] = '{1'b1, 1'b1, 4'h0, 4'hA, 32'h0, 32'h0000_0005};

        rst_n = 1'b0; sel = 1'b0; addr = 4'h8; wdata = 32'h0; wenable = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data", {24'h0, lcd_data}, 32'h0);
        check("rst_ctrl", {30'h0, lcd_ctrl}, 32'h0);
        check("rst_en", {31'h0, lcd_enable}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_status", rdata, 32'h0000_0004);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Register-map vectors, one bus cycle each
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            sel = vecs[i].sel; addr = vecs[i].addr; wdata = vecs[i].wdata;
            wenable = vecs[i].is_rd ? 4'h0 : vecs[i].wen;
            #1;
            if (vecs[i].is_rd) check($sformatf("vec%0d", i), rdata, vecs[i].exp);
            @(posedge clk);
            #1;
            sel = 1'b0; wenable = 4'h0;
        end
        @(negedge clk);
        check("vec_lcd_data", {24'h0, lcd_data}, 32'h1);
        check("vec_lcd_ctrl", {30'h0, lcd_ctrl}, 32'h0);
        wait_level(1, 1'b0, 200, t, ok);
        check("vec_drain", {31'h0, ok}, 32'h1);

        // Scenario 1: single DATA write
        xfer_check(1'b1, 8'h41);

        // Scenario 2: CMD then DATA back-to-back
        rise_q.delete();
        bus_write(4'h4, 32'h01);
        bus_write(4'h0, 32'h48);
        @(negedge clk);
        wait_level(1, 1'b0, 300, t, ok);
        check("s2_drain", {31'h0, ok}, 32'h1);
        check("s2_count", 32'(rise_q.size()), 32'd2);
        if (rise_q.size() >= 2) begin
            check("s2_period", 32'(rise_q[1].cyc - rise_q[0].cyc), 32'(1 + SETUP + PULSE + HOLD + WAITC));
            check("s2_ctrl0", {30'h0, rise_q[0].ctrl}, 32'h0);
            check("s2_data0", {24'h0, rise_q[0].data}, 32'h01);
            check("s2_ctrl1", {30'h0, rise_q[1].ctrl}, 32'h2);
            check("s2_data1", {24'h0, rise_q[1].data}, 32'h48);
        end

        // Scenario 3: burst of 10 into an 8-deep FIFO
        rise_q.delete();
        for (int i = 0; i < 10; i++) bus_write(4'h0, 32'h30 + 32'(i));
        bus_read(4'h8, 32'h0008_0103, "s3_status_ovf");
        bus_write(4'hC, 32'h1);
        bus_read(4'h8, 32'h0007_0001, "s3_status_clr");
        wait_level(1, 1'b0, 300, t, ok);
        check("s3_drain", {31'h0, ok}, 32'h1);
        check("s3_accepted", 32'(rise_q.size()), 32'd9);
        for (int i = 0; i < rise_q.size() && i < 9; i++)
            check($sformatf("s3_data%0d", i), {24'h0, rise_q[i].data}, 32'h30 + 32'(i));

        // Scenario 4: flush mid-pulse
        for (int i = 0; i < 9; i++) bus_write(4'h0, 32'h78);
        bus_read(4'h8, 32'h0008_0003, "s4_full");
        rise_q.delete();
        wait_level(0, 1'b1, 30, t, ok);
        check("s4_pulse_seen", {31'h0, ok}, 32'h1);
        bus_write(4'hC, 32'h2);
        bus_read(4'h8, 32'h0000_0005, "s4_flushed");
        wait_level(1, 1'b0, 100, t, ok);
        check("s4_drain", {31'h0, ok}, 32'h1);
        repeat (20) @(negedge clk);
        check("s4_one_pulse", 32'(rise_q.size()), 32'd1);
        bus_read(4'h8, 32'h0000_0004, "s4_status_idle");

        // Scenario 5: reset during PULSE
        sel = 1'b0;
        bus_write(4'h0, 32'h72);
        bus_write(4'h0, 32'h73);
        bus_write(4'h0, 32'h74);
        @(negedge clk);
        wait_level(0, 1'b1, 30, t, ok);
        check("s5_pulse_seen", {31'h0, ok}, 32'h1);
        chk_width = 1'b0;
        rst_n = 1'b0; addr = 4'h8;
        @(posedge clk);
        #1;
        check("s5_en", {31'h0, lcd_enable}, 32'h0);
        check("s5_data", {24'h0, lcd_data}, 32'h0);
        check("s5_ctrl", {30'h0, lcd_ctrl}, 32'h0);
        check("s5_busy", {31'h0, busy}, 32'h0);
        check("s5_status", rdata, 32'h0000_0004);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_width = 1'b1;
        xfer_check(1'b1, 8'h41);

        // Scenario 6: random DATA/CMD writes against an LCD-side scoreboard
        rise_q.delete();
        exp_q.delete();
        for (int i = 0; i < 20; i++) begin
            rs = 1'($urandom_range(0, 1));
            d  = 8'h61 + 8'($urandom_range(0, 25));
            exp_q.push_back('{0, {rs, 1'b0}, d});
            xfer_check(rs, d);
        end
        check("s6_count", 32'(rise_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rise_q.size(); i++)
            check($sformatf("s6_entry%0d", i), {22'h0, rise_q[i].ctrl, rise_q[i].data},
                  {22'h0, exp_q[i].ctrl, exp_q[i].data});

        $display("");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
